// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU op codes
// and the shift FSM state encoding.
package execute_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_SRL  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_SUB  = 3'b100
  } aluOp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/exec_alu.sv
// Single-cycle combinational ALU for the execute stage; unknown op codes
// produce a zero result.
module exec_alu #(
  parameter int XLEN = execute_pkg::XLEN,
  parameter int SHW  = execute_pkg::SHW
) (
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [2:0]      aluControl,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  import execute_pkg::*;

  always_comb begin
    result = '0;
    case (aluControl)
      ALU_ADD:  result = srcA + srcB;
      ALU_OR:   result = srcA | srcB;
      ALU_SRL:  result = srcA >> srcB[SHW-1:0];
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (srcA < srcB)};
      ALU_SUB:  result = srcA - srcB;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute.sv
// Execute stage: registers the decoded instruction into the writeback bundle.
// SRL by a non-zero amount runs one bit per cycle and stalls decode meanwhile.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | accepting from decode; non-SRL (or SRL by 0) completes in 1 cycle
//   SHIFT | iterative SRL in progress, stall_o high, inputs ignored
module execute #(
  parameter int XLEN = execute_pkg::XLEN,
  parameter int SHW  = execute_pkg::SHW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            stall_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] rd2_i,
  input  logic [XLEN-1:0] immI_i,
  input  logic [XLEN-1:0] immB_i,
  input  logic [XLEN-1:0] immU_i,
  input  logic            aluSrc_i,
  input  logic [2:0]      aluControl_i,
  input  logic            regWrite_i,
  input  logic            wdSrc_i,
  input  logic            branch_i,
  input  logic            condZero_i,
  input  logic [4:0]      rd_i,
  output logic            regWrite_o,
  output logic            wdSrc_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] immU_o,
  output logic [XLEN-1:0] aluResult_o,
  output logic            aluZero_o,
  output logic            condZero_o,
  output logic            branch_o,
  output logic [XLEN-1:0] pcBranch_o,
  output logic [XLEN-1:0] pcPlus4_o
);
  import execute_pkg::*;

  typedef struct packed {
    logic            regWrite;
    logic            wdSrc;
    logic [4:0]      rd;
    logic [XLEN-1:0] immU;
    logic            condZero;
    logic            branch;
    logic [XLEN-1:0] pcBranch;
    logic [XLEN-1:0] pcPlus4;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] result;
    logic            zero;
  } wb_t;

  state_t          state, stateNext;
  logic [SHW-1:0]  cnt, cntNext;
  logic [XLEN-1:0] shreg, shregNext;
  ctrl_t           cap, capNext;
  wb_t             outQ, outNext;

  logic [XLEN-1:0] srcB;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] aluResult;
  logic            aluZero;
  logic [XLEN-1:0] shregShifted;
  ctrl_t           ctrlIn;

  assign srcB         = aluSrc_i ? immI_i : rd2_i;
  assign shamt        = srcB[SHW-1:0];
  assign shregShifted = shreg >> 1;

  always_comb begin
    ctrlIn          = '0;
    ctrlIn.regWrite = regWrite_i;
    ctrlIn.wdSrc    = wdSrc_i;
    ctrlIn.rd       = rd_i;
    ctrlIn.immU     = immU_i;
    ctrlIn.condZero = condZero_i;
    ctrlIn.branch   = branch_i;
    ctrlIn.pcBranch = pc_i + immB_i;
    ctrlIn.pcPlus4  = pc_i + XLEN'(4);
  end

  exec_alu #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) uAlu (
    .srcA       (rd1_i),
    .srcB       (srcB),
    .aluControl (aluControl_i),
    .result     (aluResult),
    .zero       (aluZero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      cap   <= '0;
      outQ  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      shreg <= shregNext;
      cap   <= capNext;
      outQ  <= outNext;
    end
  end

  // Output register defaults to a bubble; only a completing instruction fills it.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    shregNext = shreg;
    capNext   = cap;
    outNext   = '0;
    if (flush_i) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            if ((aluControl_i == ALU_SRL) && (shamt != '0)) begin
              capNext   = ctrlIn;
              shregNext = rd1_i;
              cntNext   = shamt;
              stateNext = SHIFT;
            end else begin
              outNext.ctrl   = ctrlIn;
              outNext.result = aluResult;
              outNext.zero   = aluZero;
            end
          end
        end
        SHIFT: begin
          shregNext = shregShifted;
          cntNext   = cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            outNext.ctrl   = cap;
            outNext.result = shregShifted;
            outNext.zero   = (shregShifted == '0);
            stateNext      = IDLE;
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  assign stall_o     = (state == SHIFT);
  assign regWrite_o  = outQ.ctrl.regWrite;
  assign wdSrc_o     = outQ.ctrl.wdSrc;
  assign rd_o        = outQ.ctrl.rd;
  assign immU_o      = outQ.ctrl.immU;
  assign condZero_o  = outQ.ctrl.condZero;
  assign branch_o    = outQ.ctrl.branch;
  assign pcBranch_o  = outQ.ctrl.pcBranch;
  assign pcPlus4_o   = outQ.ctrl.pcPlus4;
  assign aluResult_o = outQ.result;
  assign aluZero_o   = outQ.zero;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: each driven cycle pushes the
// expected writeback bundle for the following edge, a monitor pops and compares.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        stall_o;
  logic [31:0] pc_i = '0, rd1_i = '0, rd2_i = '0, immI_i = '0, immB_i = '0, immU_i = '0;
  logic        aluSrc_i = 1'b0;
  logic [2:0]  aluControl_i = '0;
  logic        regWrite_i = 1'b0, wdSrc_i = 1'b0, branch_i = 1'b0, condZero_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        regWrite_o, wdSrc_o, aluZero_o, condZero_o, branch_o;
  logic [4:0]  rd_o;
  logic [31:0] immU_o, aluResult_o, pcBranch_o, pcPlus4_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc, rd1, rd2, immI, immB, immU;
    logic        aluSrc;
    logic [2:0]  op;
    logic        regWrite, wdSrc, branch, condZero;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    logic        regWrite, wdSrc;
    logic [4:0]  rd;
    logic [31:0] immU, result;
    logic        zero, condZero, branch;
    logic [31:0] pcBranch, pcPlus4;
    logic        stall;
  } exp_t;

  exp_t expQ[$];

  execute dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .stall_o      (stall_o),
    .pc_i         (pc_i),
    .rd1_i        (rd1_i),
    .rd2_i        (rd2_i),
    .immI_i       (immI_i),
    .immB_i       (immB_i),
    .immU_i       (immU_i),
    .aluSrc_i     (aluSrc_i),
    .aluControl_i (aluControl_i),
    .regWrite_i   (regWrite_i),
    .wdSrc_i      (wdSrc_i),
    .branch_i     (branch_i),
    .condZero_i   (condZero_i),
    .rd_i         (rd_i),
    .regWrite_o   (regWrite_o),
    .wdSrc_o      (wdSrc_o),
    .rd_o         (rd_o),
    .immU_o       (immU_o),
    .aluResult_o  (aluResult_o),
    .aluZero_o    (aluZero_o),
    .condZero_o   (condZero_o),
    .branch_o     (branch_o),
    .pcBranch_o   (pcBranch_o),
    .pcPlus4_o    (pcPlus4_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chkOut(input string tag, input exp_t e);
    chk({tag, ".regWrite"}, 32'(regWrite_o), 32'(e.regWrite));
    chk({tag, ".wdSrc"},    32'(wdSrc_o),    32'(e.wdSrc));
    chk({tag, ".rd"},       32'(rd_o),       32'(e.rd));
    chk({tag, ".immU"},     immU_o,          e.immU);
    chk({tag, ".result"},   aluResult_o,     e.result);
    chk({tag, ".zero"},     32'(aluZero_o),  32'(e.zero));
    chk({tag, ".condZero"}, 32'(condZero_o), 32'(e.condZero));
    chk({tag, ".branch"},   32'(branch_o),   32'(e.branch));
    chk({tag, ".pcBranch"}, pcBranch_o,      e.pcBranch);
    chk({tag, ".pcPlus4"},  pcPlus4_o,       e.pcPlus4);
    chk({tag, ".stall"},    32'(stall_o),    32'(e.stall));
  endtask

  function automatic exp_t bubble(input logic stall);
    exp_t e;
    e = '{default: '0};
    e.stall = stall;
    return e;
  endfunction

  function automatic exp_t mkExp(input stim_t s, input logic [31:0] r);
    exp_t e;
    e.regWrite = s.regWrite;
    e.wdSrc    = s.wdSrc;
    e.rd       = s.rd;
    e.immU     = s.immU;
    e.result   = r;
    e.zero     = (r == 32'd0);
    e.condZero = s.condZero;
    e.branch   = s.branch;
    e.pcBranch = s.pc + s.immB;
    e.pcPlus4  = s.pc + 32'd4;
    e.stall    = 1'b0;
    return e;
  endfunction

  function automatic stim_t rndStim(input logic [2:0] op);
    stim_t s;
    s.pc       = $urandom;
    s.rd1      = $urandom;
    s.rd2      = $urandom;
    s.immI     = $urandom;
    s.immB     = $urandom;
    s.immU     = $urandom;
    s.aluSrc   = 1'($urandom);
    s.op       = op;
    s.regWrite = 1'($urandom);
    s.wdSrc    = 1'($urandom);
    s.branch   = 1'($urandom);
    s.condZero = 1'($urandom);
    s.rd       = 5'($urandom);
    return s;
  endfunction

  function automatic logic [31:0] refAlu(input stim_t s);
    logic [31:0] b;
    b = s.aluSrc ? s.immI : s.rd2;
    case (s.op)
      3'b000:  return s.rd1 + b;
      3'b001:  return s.rd1 | b;
      3'b011:  return (s.rd1 < b) ? 32'd1 : 32'd0;
      3'b100:  return s.rd1 - b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic apply(input stim_t s, input logic v, input logic f);
    @(negedge clk);
    pc_i = s.pc; rd1_i = s.rd1; rd2_i = s.rd2;
    immI_i = s.immI; immB_i = s.immB; immU_i = s.immU;
    aluSrc_i = s.aluSrc; aluControl_i = s.op;
    regWrite_i = s.regWrite; wdSrc_i = s.wdSrc;
    branch_i = s.branch; condZero_i = s.condZero; rd_i = s.rd;
    valid_i = v; flush_i = f;
  endtask

  task automatic issue(input stim_t s, input logic v, input logic f, input exp_t e);
    apply(s, v, f);
    expQ.push_back(e);
  endtask

  // SRL by n (n >= 1): accept edge plus n-1 shift edges are stalled bubbles.
  task automatic srlRun(input stim_t s, input int n, input logic [31:0] r);
    issue(s, 1'b1, 1'b0, bubble(1'b1));
    for (int k = 1; k < n; k++) issue(s, 1'b1, 1'b0, bubble(1'b1));
    issue(s, 1'b1, 1'b0, mkExp(s, r));
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chkOut("sb", e);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, a;

    for (int i = 0; i < 3; i++) begin
      apply(rndStim(3'($urandom)), 1'b1, 1'b0);
      #1 chkOut("reset", bubble(1'b0));
    end
    a = rndStim(3'b000);
    apply(a, 1'b0, 1'b0);
    rst_n = 1'b1;
    issue(a, 1'b0, 1'b0, bubble(1'b0));
    issue(a, 1'b0, 1'b0, bubble(1'b0));

    s = rndStim(3'b000);
    s.rd1 = 32'd5; s.immI = 32'hFFFF_FFFF; s.aluSrc = 1'b1; s.regWrite = 1'b1;
    s.rd = 5'd3; s.pc = 32'h100; s.immB = 32'd8;
    issue(s, 1'b1, 1'b0, mkExp(s, 32'd4));
    issue(s, 1'b0, 1'b0, bubble(1'b0));

    s = rndStim(3'b100);
    s.rd1 = 32'd7; s.rd2 = 32'd7; s.aluSrc = 1'b0; s.branch = 1'b1; s.condZero = 1'b1;
    issue(s, 1'b1, 1'b0, mkExp(s, 32'd0));
    s = rndStim(3'b011);
    s.rd1 = 32'd1; s.rd2 = 32'hFFFF_FFFF; s.aluSrc = 1'b0;
    issue(s, 1'b1, 1'b0, mkExp(s, 32'd1));
    s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1;
    issue(s, 1'b1, 1'b0, mkExp(s, 32'd0));
    s = rndStim(3'b001);
    s.rd1 = 32'hF0F0_0000; s.rd2 = 32'h0000_0F0F; s.aluSrc = 1'b0;
    issue(s, 1'b1, 1'b0, mkExp(s, 32'hF0F0_0F0F));
    s = rndStim(3'b111);
    issue(s, 1'b1, 1'b0, mkExp(s, 32'd0));
    s = rndStim(3'b101);
    issue(s, 1'b1, 1'b0, mkExp(s, 32'd0));

    for (int i = 0; i < 16; i++) begin
      logic [2:0] ops [4];
      ops = '{3'b000, 3'b001, 3'b011, 3'b100};
      s = rndStim(ops[i % 4]);
      issue(s, 1'b1, 1'b0, mkExp(s, refAlu(s)));
    end

    s = rndStim(3'b010);
    s.rd1 = 32'h8000_0000; s.immI = 32'd4; s.aluSrc = 1'b1;
    srlRun(s, 4, 32'h0800_0000);
    a = rndStim(3'b000);
    issue(a, 1'b1, 1'b0, mkExp(a, refAlu(a)));

    s = rndStim(3'b010);
    s.rd2 = 32'h20; s.aluSrc = 1'b0;
    issue(s, 1'b1, 1'b0, mkExp(s, s.rd1));

    s = rndStim(3'b010);
    s.rd1 = 32'hFFFF_FFFF; s.immI = 32'd31; s.aluSrc = 1'b1;
    srlRun(s, 31, 32'd1);

    s = rndStim(3'b010);
    s.rd2 = 32'h25; s.aluSrc = 1'b0;
    srlRun(s, 5, s.rd1 >> 5);

    s = rndStim(3'b010);
    s.rd1 = 32'hDEAD_BEEF; s.immI = 32'd6; s.aluSrc = 1'b1;
    issue(s, 1'b1, 1'b0, bubble(1'b1));
    issue(s, 1'b1, 1'b0, bubble(1'b1));
    issue(s, 1'b1, 1'b1, bubble(1'b0));
    for (int i = 0; i < 8; i++) issue(s, 1'b0, 1'b0, bubble(1'b0));
    a = rndStim(3'b000);
    issue(a, 1'b1, 1'b1, bubble(1'b0));
    issue(a, 1'b1, 1'b0, mkExp(a, refAlu(a)));

    s = rndStim(3'b010);
    s.rd1 = 32'hFFFF_0000; s.immI = 32'd10; s.aluSrc = 1'b1;
    issue(s, 1'b1, 1'b0, bubble(1'b1));
    issue(s, 1'b1, 1'b0, bubble(1'b1));
    issue(s, 1'b1, 1'b0, bubble(1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    #1 chkOut("midReset", bubble(1'b0));
    @(negedge clk);
    chkOut("heldReset", bubble(1'b0));
    a = rndStim(3'b001);
    apply(a, 1'b0, 1'b0);
    rst_n = 1'b1;
    expQ.push_back(bubble(1'b0));
    issue(a, 1'b1, 1'b0, mkExp(a, refAlu(a)));
    issue(a, 1'b0, 1'b0, bubble(1'b0));

    repeat (3) @(negedge clk);
    chk("drain", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage of the pipelined core. Sits between decode and writeback and drives every writeback input directly.
- Registers the decoded instruction, computes the ALU result, zero flag, branch target and PC+4.
- SRL runs iteratively, one bit per cycle, under a small FSM. While it runs, `stall_o` holds decode.

Parameters:
- XLEN, 32, datapath width; the design is tested only at 32.
- SHW, 5, shift-amount width (log2 XLEN).

Ports:
- clk  in  1  clock; all flops on posedge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  kill the in-flight/accepted instruction, output a bubble
- valid_i  in  1  decode presents an instruction this cycle
- stall_o  out  1  decode must hold its outputs stable
- pc_i  in  XLEN  instruction PC
- rd1_i  in  XLEN  register operand A
- rd2_i  in  XLEN  register operand B
- immI_i  in  XLEN  I-immediate
- immB_i  in  XLEN  B-immediate
- immU_i  in  XLEN  U-immediate
- aluSrc_i  in  1  1 selects immI as operand B, 0 selects rd2
- aluControl_i  in  3  ALU op
- regWrite_i  in  1  writes rd
- wdSrc_i  in  1  1 selects ALU result, 0 selects immU
- branch_i  in  1  conditional branch
- condZero_i  in  1  branch-taken polarity
- rd_i  in  5  destination register
- regWrite_o, wdSrc_o, rd_o, immU_o, aluResult_o, aluZero_o, condZero_o, branch_o, pcBranch_o, pcPlus4_o  out  widths as the matching inputs (aluZero 1, pcBranch/pcPlus4 XLEN)  registered to writeback

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, shift count 0, stall_o 0.
- Operands: srcA = rd1_i; srcB = aluSrc_i ? immI_i : rd2_i.
- ALU ops: ADD 000, OR 001, SRL 010, SLTU 011, SUB 100. Other codes give result 0.
- SLTU is unsigned and zero-extended. ADD/SUB wrap modulo 2^XLEN.
- Derived outputs: pcBranch = pc_i + immB_i; pcPlus4 = pc_i + 4, both wrap. aluZero = (result == 0).
- Bubble: regWrite_o = 0, branch_o = 0, and every other output = 0.
- IDLE, valid_i=1, op is not SRL or shamt = srcB[4:0] = 0:
  - Outputs take the computed values at this same posedge (latency 1).
  - Stay in IDLE.
- IDLE, valid_i=1, op is SRL and shamt = N > 0:
  - Capture the control fields, srcA and pc-derived values.
  - Set cnt = N; go to SHIFT; outputs become a bubble.
- IDLE, valid_i=0: outputs become a bubble.
- SHIFT:
  - stall_o = 1, combinationally from state.
  - Each posedge: shreg >>= 1 (logical), cnt -= 1, outputs stay a bubble.
  - When cnt == 1: outputs take the final shifted value and the captured fields, and state returns to IDLE.
  - SRL by N therefore occupies the stage for N+1 cycles; stall_o is high for N cycles.
- stall_o = 0 in IDLE. Decode's held instruction is accepted on the first IDLE edge.
- Inputs are ignored in SHIFT. Decode must keep them stable while stall_o = 1.
- flush_i = 1 at a posedge, any state:
  - Outputs become a bubble, state goes to IDLE, cnt goes to 0.
  - No instruction is accepted on that edge.
  - flush_i overrides valid_i and SHIFT completion.
- Reset asserted mid-SHIFT: immediate return to reset values; the instruction is lost.
- aluZero for SRL is computed on the final shifted value.

Decomposition:
- Shared package holds:
  - the ALU op codes (ALU_ADD, ALU_OR, ALU_SRL, ALU_SLTU, ALU_SUB);
  - the state encoding (IDLE, SHIFT);
  - XLEN.
- One sub-module, exec_alu: combinational, takes srcA, srcB and aluControl, returns result and zero.
  - It computes SRL in a single step.
- The iterative SRL shift path and its FSM live in execute itself. exec_alu's SRL result is not used for N>0.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, stall_o 0. Release -> still 0 until valid_i.
- ADD: rd1=5, immI=0xFFFFFFFF, aluSrc=1, regWrite=1, rd=3, pc=0x100, immB=8, valid for 1 cycle -> next edge: aluResult=4, aluZero=0, rd_o=3, regWrite_o=1, pcPlus4=0x104, pcBranch=0x108. Edge after that: bubble.
- SUB/branch: rd1=rd2=7, SUB, branch=1, condZero=1 -> aluResult=0, aluZero=1, branch_o=1. SLTU 1 vs 0xFFFFFFFF -> result 1.
- SRL 0x80000000 by 4:
  - stall_o high exactly 4 cycles, with 4 bubble outputs after the accept edge.
  - Result 0x08000000 appears on the 4th edge after accept.
  - A following ADD held during the stall completes on the next edge.
- SRL by 0 -> single-cycle, result = rd1, stall_o never asserts. SRL by 31 of 0xFFFFFFFF -> result 1 after 31 stall cycles.
- Flush and reset mid-shift:
  - flush_i in the 2nd SHIFT cycle of a shift by 6 -> bubble output, stall_o drops next cycle, no SRL result ever appears.
  - rst_n low mid-SHIFT -> outputs 0 immediately.
